// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the 4-input truth-table scanner and its index streamer.
package tt_scan_pkg;

    localparam int NUM_MINTERMS = 16;
    localparam int IDX_W        = 4;

    typedef logic [NUM_MINTERMS-1:0] mask_t;
    typedef logic [IDX_W-1:0]        idx_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_MINTERMS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } state_t;

    function automatic mask_t minterm_onehot(input idx_t idx);
        minterm_onehot = mask_t'(1) << idx;
    endfunction

    // Lowest set bit wins; returns 0 for an empty mask (callers qualify with |mask).
    function automatic idx_t lowest_set(input mask_t m);
        lowest_set = '0;
        for (int i = NUM_MINTERMS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = idx_t'(i);
        end
    endfunction

endpackage

// File: rtl/tt_index_streamer.sv
// Streams the indices of set bits of a loaded mask, ascending, over valid/ready with last.
module tt_index_streamer
    import tt_scan_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  mask_t       mask,
    input  logic        ready,
    output logic        valid,
    output idx_t        data,
    output logic        last
);

    // Bits still to be emitted after the beat currently presented on data.
    mask_t remaining;
    mask_t src;
    mask_t next_rem;
    idx_t  next_idx;

    always_comb begin
        src      = load ? mask : remaining;
        next_idx = lowest_set(src);
        next_rem = src & ~minterm_onehot(next_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= 1'b0;
            data      <= '0;
            last      <= 1'b0;
            remaining <= '0;
        end else if (load) begin
            valid     <= |mask;
            data      <= next_idx;
            last      <= (|mask) && (next_rem == '0);
            remaining <= next_rem;
        end else if (valid && ready) begin
            if (|remaining) begin
                data      <= next_idx;
                last      <= (next_rem == '0);
                remaining <= next_rem;
            end else begin
                valid <= 1'b0;
                last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Drives all 16 minterms into a 4-input function pair, captures both truth tables,
// flags disagreements and streams the on-set of the first function.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic        s1_in,
    input  logic        s2_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt_s1,
    output logic [15:0] tt_s2,
    output logic [15:0] mismatch_mask,
    output logic        mismatch,
    output logic [4:0]  minterm_count,
    output logic        idx_valid,
    input  logic        idx_ready,
    output logic [3:0]  idx_data,
    output logic        idx_last
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             load;

    assign mismatch_mask = tt_s1 ^ tt_s2;
    assign mismatch      = |mismatch_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            settle_cnt    <= RELOAD;
            abcd          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            load          <= 1'b0;
            tt_s1         <= '0;
            tt_s2         <= '0;
            minterm_count <= '0;
        end else begin
            done <= 1'b0;
            load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= DRIVE;
                        busy          <= 1'b1;
                        abcd          <= '0;
                        settle_cnt    <= RELOAD;
                        tt_s1         <= '0;
                        tt_s2         <= '0;
                        minterm_count <= '0;
                    end
                end
                DRIVE: begin
                    // Sample on the last cycle of the settle window, SETTLE edges after abcd moved.
                    if (settle_cnt == '0) begin
                        tt_s1[abcd] <= s1_in;
                        tt_s2[abcd] <= s2_in;
                        if (s1_in) minterm_count <= minterm_count + 5'd1;
                        if (abcd != LAST_IDX) begin
                            abcd       <= abcd + 4'd1;
                            settle_cnt <= RELOAD;
                        end else begin
                            state <= STREAM;
                            load  <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                STREAM: begin
                    // The streamer sees the completed tt_s1 one cycle after the last sample.
                    if ((minterm_count == '0) || (idx_valid && idx_ready && idx_last)) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    tt_index_streamer u_streamer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .mask  (tt_s1),
        .ready (idx_ready),
        .valid (idx_valid),
        .data  (idx_data),
        .last  (idx_last)
    );

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed-vector bench for truth_table_scanner: scan results, index stream, stalls, restarts and reset abort.
module tb_truth_table_scanner;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  abcd;
    logic        s1_in, s2_in;
    logic        busy, done;
    logic [15:0] tt_s1, tt_s2, mismatch_mask;
    logic        mismatch;
    logic [4:0]  minterm_count;
    logic        idx_valid;
    logic        idx_ready = 1'b0;
    logic [3:0]  idx_data;
    logic        idx_last;

    logic [15:0] f1 = '0;
    logic [15:0] f2 = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Logic under test: each function is just its truth table looked up by abcd.
    assign s1_in = f1[abcd];
    assign s2_in = f2[abcd];

    always #5 clk = ~clk;

    truth_table_scanner #(.SETTLE(SETTLE), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abcd          (abcd),
        .s1_in         (s1_in),
        .s2_in         (s2_in),
        .busy          (busy),
        .done          (done),
        .tt_s1         (tt_s1),
        .tt_s2         (tt_s2),
        .mismatch_mask (mismatch_mask),
        .mismatch      (mismatch),
        .minterm_count (minterm_count),
        .idx_valid     (idx_valid),
        .idx_ready     (idx_ready),
        .idx_data      (idx_data),
        .idx_last      (idx_last)
    );

    typedef struct {
        logic [15:0] f1;
        logic [15:0] f2;
        logic [15:0] exp_tt1;
        logic [15:0] exp_tt2;
        logic [15:0] exp_mm;
        logic        exp_mis;
        logic [4:0]  exp_cnt;
        int          stall;
        bit          repulse;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_abcd"}, abcd, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tt_s1"}, tt_s1, 0);
        check({tag, "_tt_s2"}, tt_s2, 0);
        check({tag, "_mismatch"}, mismatch, 0);
        check({tag, "_count"}, minterm_count, 0);
        check({tag, "_idx_valid"}, idx_valid, 0);
        check({tag, "_idx_last"}, idx_last, 0);
    endtask

    task automatic run_scan(input vec_t v);
        int exp_list[$];
        int k, ptr, waits, n;
        bit seen;
        for (int i = 0; i < 16; i++) if (v.exp_tt1[i]) exp_list.push_back(i);
        n = exp_list.size();
        f1 = v.f1;
        f2 = v.f2;
        idx_ready = (v.stall == 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; ptr = 0; waits = 0; seen = 0;
        // k counts edges since the one that accepted start.
        while (!seen && k < 400) begin
            start = v.repulse && (k == 5 || k == 34);
            if (k == 0) check("busy_after_start", busy, 1);
            if (k < 16 * SETTLE && (k % SETTLE) == 0) check("abcd_seq", abcd, k / SETTLE);
            if (idx_valid) begin
                if (ptr >= n) begin
                    check("extra_beat_valid", idx_valid, 0);
                    idx_ready = 1'b1;
                end else begin
                    check("idx_data", idx_data, exp_list[ptr]);
                    check("idx_last", idx_last, (ptr == n - 1));
                    if (waits >= v.stall) begin
                        idx_ready = 1'b1;
                        ptr++;
                        waits = 0;
                    end else begin
                        idx_ready = 1'b0;
                        waits++;
                    end
                end
            end else begin
                idx_ready = (v.stall == 0);
            end
            if (done) begin
                seen = 1;
                if (n == 0) check("done_latency", k, 16 * SETTLE + 1);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("beats_emitted", ptr, n);
        check("abcd_hold_15", abcd, 15);
        check("tt_s1", tt_s1, v.exp_tt1);
        check("tt_s2", tt_s2, v.exp_tt2);
        check("mismatch_mask", mismatch_mask, v.exp_mm);
        check("mismatch", mismatch, v.exp_mis);
        check("minterm_count", minterm_count, v.exp_cnt);
        repeat (3) begin
            @(negedge clk);
            check("no_extra_done", done, 0);
        end
    endtask

    initial begin
        vecs[0] = '{16'hD0C4, 16'hD4C4, 16'hD0C4, 16'hD4C4, 16'h0400, 1'b1, 5'd6,  0, 1'b1};
        vecs[1] = '{16'hD0C4, 16'hD4C4, 16'hD0C4, 16'hD4C4, 16'h0400, 1'b1, 5'd6,  3, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0,  0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 5'd16, 0, 1'b0};
        vecs[4] = '{16'h8001, 16'h0001, 16'h8001, 16'h0001, 16'h8000, 1'b1, 5'd2,  1, 1'b0};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++) run_scan(vecs[t]);

        // Abort a scan part-way through minterm 7 with an asynchronous reset.
        f1 = vecs[0].f1;
        f2 = vecs[0].f2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 100 && abcd != 4'd7; w++) @(negedge clk);
        check("reached_minterm_7", abcd, 7);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            check("no_done_after_abort", done, 0);
        end
        run_scan(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
